spi_serf: RTL and testbench

- SPI responder (serf) for the 16-bit SPI monarch used across the e-bike design. Lets on-chip peripheral models (sensor/IMU/ADC stand-ins) answer monarch transactions in simulation and on FPGA.
- Receives a 16-bit command on MOSI and returns a preloaded 16-bit response on MISO in the same frame.
- Runs entirely in the system clk domain. SS_n, SCLK and MOSI are synchronized and edge-detected; no logic is clocked by SCLK.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_sync_edge.sv | 46 ++++
 rtl/spi_serf.sv | 167 ++++++++++++++++
 tb/tb_spi_serf.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the 16-bit SPI monarch/serf pair.
//   SPI_W        : frame width used by both ends of the link
//   serf_state_t : responder frame state (IDLE between frames, ACTIVE in one)
// ---------------------------------------------------------------------------
package spi_pkg;

  localparam int SPI_W = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } serf_state_t;

endpackage : spi_pkg

// File: rtl/spi_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_sync_edge
// Three-flop synchronizer for an asynchronous level, with edge detection.
// Flops 1-2 resolve metastability, flop 3 holds the previous synchronized
// value so edges are detected on flop 2 versus flop 3.
//
// Ports:
//   clk     input   system clock
//   rst_n   input   asynchronous active-low reset (chain resets to RST_VAL)
//   d_i     input   asynchronous level to synchronize
//   lvl_o   output  synchronized level (flop 3)
//   rise_o  output  one-clk pulse on a 0->1 transition (ff2 & ~ff3)
//   fall_o  output  one-clk pulse on a 1->0 transition (~ff2 & ff3)
// ---------------------------------------------------------------------------
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic ff1_q;
  logic ff2_q;
  logic ff3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff1_q <= RST_VAL;
      ff2_q <= RST_VAL;
      ff3_q <= RST_VAL;
    end else begin
      ff1_q <= d_i;
      ff2_q <= ff1_q;
      ff3_q <= ff2_q;
    end
  end

  assign lvl_o  = ff3_q;
  assign rise_o = ff2_q & ~ff3_q;
  assign fall_o = ~ff2_q & ff3_q;

endmodule : spi_sync_edge

// File: rtl/spi_serf.sv
// ---------------------------------------------------------------------------
// spi_serf
// SPI responder for the 16-bit SPI monarch. Receives a command on MOSI and
// returns a preloaded response on MISO within the same frame. SCLK idles
// high; the monarch changes MOSI on SCLK fall and samples MISO on SCLK rise.
// Everything runs on clk: SS_n, SCLK and MOSI are synchronized and
// edge-detected, nothing is clocked by SCLK.
//
// Ports:
//   clk       input   system clock
//   rst_n     input   asynchronous active-low reset
//   SS_n      input   serf select, active low
//   SCLK      input   serial clock from monarch (idles high)
//   MOSI      input   serial data from monarch, MSB first
//   MISO      output  serial data to monarch, MSB first (0 when not selected)
//   wrt       input   one-clk strobe: load tx_data as the next response
//   tx_data   input   response word for the next frame
//   clr_rdy   input   one-clk strobe: clear rdy
//   cmd_rcvd  output  last correctly framed command
//   rdy       output  level: cmd_rcvd holds a new command
//   frm_err   output  one-clk pulse: frame ended with wrong bit count
// ---------------------------------------------------------------------------
module spi_serf
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  input  logic              wrt,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              clr_rdy,
  output logic [DATA_W-1:0] cmd_rcvd,
  output logic              rdy,
  output logic              frm_err
);

  // Bit counter must hold 0..DATA_W+1; DATA_W+1 marks "too many bits".
  localparam int                CNT_W    = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(DATA_W + 1);

  // Synchronized inputs and edges
  logic ss_lvl;
  logic ss_rise;
  logic ss_fall;
  logic sclk_lvl_unused;
  logic sclk_rise;
  logic sclk_fall;
  logic [2:0] mosi_sync_q;

  // Frame state
  serf_state_t       state_q;
  logic [DATA_W-1:0] shft_q;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] cmd_rcvd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              seen_rise_q;
  logic              mosi_smpl_q;
  logic              rdy_q;
  logic              frm_err_q;
  logic [DATA_W-1:0] frame_d;

  spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (SS_n),
    .lvl_o  (ss_lvl),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (SCLK),
    .lvl_o  (sclk_lvl_unused),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  // MOSI only needs the delay chain so it stays aligned with the SCLK edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_sync_q <= 3'b000;
    end else begin
      mosi_sync_q <= {mosi_sync_q[1:0], MOSI};
    end
  end

  // The last bit is sampled on the final SCLK rise but never shifted in,
  // because no SCLK fall follows it; append it when the frame closes.
  assign frame_d = {shft_q[DATA_W-2:0], mosi_smpl_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shft_q      <= '0;
      hold_q      <= '0;
      cmd_rcvd_q  <= '0;
      cnt_q       <= '0;
      seen_rise_q <= 1'b0;
      mosi_smpl_q <= 1'b0;
      rdy_q       <= 1'b0;
      frm_err_q   <= 1'b0;
    end else begin
      frm_err_q <= 1'b0;

      // Later assignments below (ss_fall clear, good-frame set) override this.
      if (clr_rdy) begin
        rdy_q <= 1'b0;
      end

      // The holding register always follows wrt; the word in flight lives in
      // shft_q, so a mid-frame write only affects the next frame.
      if (wrt) begin
        hold_q <= tx_data;
      end

      case (state_q)
        IDLE: begin
          if (ss_fall) begin
            shft_q      <= wrt ? tx_data : hold_q;
            cnt_q       <= '0;
            seen_rise_q <= 1'b0;
            rdy_q       <= 1'b0;
            state_q     <= ACTIVE;
          end
        end

        ACTIVE: begin
          if (ss_rise) begin
            if (cnt_q == CNT_FULL) begin
              cmd_rcvd_q <= frame_d;
              rdy_q      <= 1'b1;
            end else begin
              frm_err_q  <= 1'b1;
            end
            state_q <= IDLE;
          end else if (sclk_rise) begin
            mosi_smpl_q <= mosi_sync_q[2];
            seen_rise_q <= 1'b1;
            if (cnt_q != CNT_SAT) begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (sclk_fall && seen_rise_q) begin
            // The idle-high SCLK's first fall precedes any rise and must not
            // shift, otherwise the response MSB would be lost.
            shft_q <= frame_d;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign MISO     = ~ss_lvl & shft_q[DATA_W-1];
  assign cmd_rcvd = cmd_rcvd_q;
  assign rdy      = rdy_q;
  assign frm_err  = frm_err_q;

endmodule : spi_serf

// File: tb/tb_spi_serf.sv
module tb_spi_serf;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic        wrt;
  logic [15:0] tx_data;
  logic        clr_rdy;
  logic [15:0] cmd_rcvd;
  logic        rdy;
  logic        frm_err;

  int n_vec = 0;
  int n_bad = 0;
  int ferr_cnt = 0;

  spi_serf #(.DATA_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .wrt      (wrt),
    .tx_data  (tx_data),
    .clr_rdy  (clr_rdy),
    .cmd_rcvd (cmd_rcvd),
    .rdy      (rdy),
    .frm_err  (frm_err)
  );

  always #5 clk = ~clk;

  // Counts clocks during which frm_err is high: one pulse == exactly 1.
  always @(negedge clk) begin
    if (frm_err === 1'b1) ferr_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_tx(input logic [15:0] w);
    tx_data = w;
    wrt = 1'b1;
    tick(1);
    wrt = 1'b0;
  endtask

  // Monarch model: SCLK falls, MOSI changes, SCLK rises, MISO is sampled.
  task automatic spi_frame(input logic [15:0] cmd, input int nbits,
                           input logic do_wrt, input logic [15:0] wrt_word,
                           input logic keep_ss,
                           output logic [15:0] resp, output logic miso_lead,
                           output logic rdy_mid);
    resp = 16'h0000;
    miso_lead = 1'b0;
    tick(4);
    SS_n = 1'b0;
    tick(HALF);
    rdy_mid = rdy;
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = cmd[15-i];
      tick(HALF/2);
      if (i == 0) miso_lead = MISO;
      if (do_wrt && i == 8) begin
        tx_data = wrt_word;
        wrt = 1'b1;
        tick(1);
        wrt = 1'b0;
        tick(HALF/2 - 1);
      end else begin
        tick(HALF/2);
      end
      SCLK = 1'b1;
      resp[15-i] = MISO;
      tick(HALF);
    end
    if (!keep_ss) SS_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    wrt = 1'b0; tx_data = 16'h0000; clr_rdy = 1'b0;
    #1 rst_n = 1'b0;
    tick(3);
    n_vec++; if (MISO !== 1'b0) begin n_bad++; $display("FAIL reset_miso got %b want 0", MISO); end
    n_vec++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL reset_rdy got %b want 0", rdy); end
    n_vec++; if (frm_err !== 1'b0) begin n_bad++; $display("FAIL reset_frm_err got %b want 0", frm_err); end
    n_vec++; if (cmd_rcvd !== 16'h0000) begin n_bad++; $display("FAIL reset_cmd got %h want 0000", cmd_rcvd); end
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic test_good_frame;
    logic [15:0] resp; logic lead; logic rmid; int e0;
    e0 = ferr_cnt;
    load_tx(16'hA5C3);
    spi_frame(16'h1234, 16, 1'b0, 16'h0000, 1'b0, resp, lead, rmid);
    n_vec++; if (resp !== 16'hA5C3) begin n_bad++; $display("FAIL good_resp got %h want a5c3", resp); end
    tick(2);
    n_vec++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL good_rdy_early got %b want 0", rdy); end
    tick(1);
    n_vec++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL good_rdy_3clk got %b want 1", rdy); end
    n_vec++; if (cmd_rcvd !== 16'h1234) begin n_bad++; $display("FAIL good_cmd got %h want 1234", cmd_rcvd); end
    n_vec++; if (ferr_cnt - e0 !== 0) begin n_bad++; $display("FAIL good_frm_err got %0d want 0", ferr_cnt - e0); end
    n_vec++; if (MISO !== 1'b0) begin n_bad++; $display("FAIL good_miso_idle got %b want 0", MISO); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] resp; logic lead; logic rmid;
    spi_frame(16'hFFFF, 16, 1'b1, 16'h0F0F, 1'b0, resp, lead, rmid);
    n_vec++; if (rmid !== 1'b0) begin n_bad++; $display("FAIL b2b_f1_rdy_clr got %b want 0", rmid); end
    n_vec++; if (resp !== 16'hA5C3) begin n_bad++; $display("FAIL b2b_f1_resp got %h want a5c3", resp); end
    tick(3);
    n_vec++; if (cmd_rcvd !== 16'hFFFF) begin n_bad++; $display("FAIL b2b_f1_cmd got %h want ffff", cmd_rcvd); end
    n_vec++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_f1_rdy got %b want 1", rdy); end
    spi_frame(16'h0001, 16, 1'b0, 16'h0000, 1'b0, resp, lead, rmid);
    n_vec++; if (rmid !== 1'b0) begin n_bad++; $display("FAIL b2b_f2_rdy_clr got %b want 0", rmid); end
    n_vec++; if (resp !== 16'h0F0F) begin n_bad++; $display("FAIL b2b_f2_resp got %h want 0f0f", resp); end
    tick(3);
    n_vec++; if (cmd_rcvd !== 16'h0001) begin n_bad++; $display("FAIL b2b_f2_cmd got %h want 0001", cmd_rcvd); end
    n_vec++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_f2_rdy got %b want 1", rdy); end
  endtask

  task automatic test_clr_rdy;
    logic [15:0] resp; logic lead; logic rmid;
    clr_rdy = 1'b1;
    tick(1);
    clr_rdy = 1'b0;
    n_vec++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL clr_rdy got %b want 0", rdy); end
    // clr_rdy lands on the clock that registers the good-frame ss_rise
    spi_frame(16'h5A5A, 16, 1'b0, 16'h0000, 1'b0, resp, lead, rmid);
    tick(2);
    clr_rdy = 1'b1;
    tick(1);
    clr_rdy = 1'b0;
    n_vec++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL clr_vs_set_rdy got %b want 1", rdy); end
    n_vec++; if (cmd_rcvd !== 16'h5A5A) begin n_bad++; $display("FAIL clr_vs_set_cmd got %h want 5a5a", cmd_rcvd); end
  endtask

  task automatic test_short_frame;
    logic [15:0] resp; logic lead; logic rmid; int e0;
    clr_rdy = 1'b1;
    tick(1);
    clr_rdy = 1'b0;
    e0 = ferr_cnt;
    spi_frame(16'hFFFF, 9, 1'b0, 16'h0000, 1'b0, resp, lead, rmid);
    tick(8);
    n_vec++; if (ferr_cnt - e0 !== 1) begin n_bad++; $display("FAIL short_frm_err_clks got %0d want 1", ferr_cnt - e0); end
    n_vec++; if (cmd_rcvd !== 16'h5A5A) begin n_bad++; $display("FAIL short_cmd got %h want 5a5a", cmd_rcvd); end
    n_vec++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL short_rdy got %b want 0", rdy); end
  endtask

  task automatic test_idle_lead;
    logic [15:0] resp; logic lead; logic rmid;
    load_tx(16'h8000);
    spi_frame(16'hC001, 16, 1'b0, 16'h0000, 1'b0, resp, lead, rmid);
    n_vec++; if (lead !== 1'b1) begin n_bad++; $display("FAIL lead_miso got %b want 1", lead); end
    n_vec++; if (resp !== 16'h8000) begin n_bad++; $display("FAIL lead_resp got %h want 8000", resp); end
    tick(3);
    n_vec++; if (cmd_rcvd !== 16'hC001) begin n_bad++; $display("FAIL lead_cmd got %h want c001", cmd_rcvd); end
  endtask

  task automatic test_reset_mid_frame;
    logic [15:0] resp; logic lead; logic rmid; int e0;
    load_tx(16'hFFFF);
    spi_frame(16'h0000, 7, 1'b0, 16'h0000, 1'b1, resp, lead, rmid);
    n_vec++; if (MISO !== 1'b1) begin n_bad++; $display("FAIL mid_miso_before got %b want 1", MISO); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (MISO !== 1'b0) begin n_bad++; $display("FAIL mid_rst_miso got %b want 0", MISO); end
    n_vec++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_rdy got %b want 0", rdy); end
    SS_n = 1'b1;
    SCLK = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(4);
    e0 = ferr_cnt;
    spi_frame(16'hBEEF, 16, 1'b0, 16'h0000, 1'b0, resp, lead, rmid);
    n_vec++; if (resp !== 16'h0000) begin n_bad++; $display("FAIL mid_after_resp got %h want 0000", resp); end
    tick(3);
    n_vec++; if (cmd_rcvd !== 16'hBEEF) begin n_bad++; $display("FAIL mid_after_cmd got %h want beef", cmd_rcvd); end
    n_vec++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL mid_after_rdy got %b want 1", rdy); end
    n_vec++; if (ferr_cnt - e0 !== 0) begin n_bad++; $display("FAIL mid_after_frm_err got %0d want 0", ferr_cnt - e0); end
  endtask

  initial begin
    test_reset;
    test_good_frame;
    test_back_to_back;
    test_clr_rdy;
    test_short_frame;
    test_idle_lead;
    test_reset_mid_frame;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_spi_serf
